// File: rtl/ff_driver_bank.sv
// Multi-channel tester pin driver: shared test-cycle counter, per-channel force formats,
// and a one-deep valid/ready vector buffer that is promoted at each cycle boundary.
module ff_driver_bank #(
    parameter int unsigned N_CH  = 8,
    parameter int unsigned CNT_W = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [CNT_W-1:0]  leading_edge,
    input  logic [CNT_W-1:0]  trailing_edge,
    input  logic [CNT_W-1:0]  cycle_length,
    input  logic [3*N_CH-1:0] ff,
    input  logic [N_CH-1:0]   d,
    input  logic              d_valid,
    output logic              d_ready,
    output logic [N_CH-1:0]   q,
    output logic              cycle_start,
    output logic              underrun,
    output logic              cfg_err
);

    typedef enum logic [2:0] {
        FmtNrz, FmtDnrzL, FmtRz, FmtR1, FmtSbc, FmtForce0, FmtForce1, FmtHold
    } fmt_e;

    typedef enum logic [1:0] {PhA, PhB, PhC} phase_e;

    logic [CNT_W-1:0]  cnt_q, sh_le_q, sh_te_q, sh_cl_q;
    logic [3*N_CH-1:0] sh_ff_q;
    logic [N_CH-1:0]   buf_q, act_q, q_q, q_d;
    logic              buf_full_q, cs_q, ur_q, ce_q;
    logic              promote, accept, bad_cfg;
    phase_e            phase;

    assign promote = en && ((cnt_q == '0) || (cnt_q == sh_cl_q));
    assign accept  = d_valid && !buf_full_q;
    assign bad_cfg = (cycle_length == '0) || (leading_edge == '0) ||
                     (leading_edge > trailing_edge) || (trailing_edge > cycle_length);

    // Phase is derived only from shadowed timing so mid-cycle input changes are ignored.
    always_comb begin
        if (cnt_q < sh_le_q) begin
            phase = PhA;
        end else if (cnt_q < sh_te_q) begin
            phase = PhB;
        end else begin
            phase = PhC;
        end
    end

    always_comb begin
        q_d = q_q;
        for (int i = 0; i < N_CH; i++) begin
            unique case (fmt_e'(sh_ff_q[3*i +: 3]))
                FmtNrz:    q_d[i] = act_q[i];
                FmtDnrzL:  q_d[i] = (phase == PhA) ? q_q[i] : act_q[i];
                FmtRz:     q_d[i] = (phase == PhB) ? act_q[i] : 1'b0;
                FmtR1:     q_d[i] = (phase == PhB) ? act_q[i] : 1'b1;
                FmtSbc:    q_d[i] = (phase == PhB) ? act_q[i] : ~act_q[i];
                FmtForce0: q_d[i] = 1'b0;
                FmtForce1: q_d[i] = 1'b1;
                FmtHold:   q_d[i] = q_q[i];
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q      <= '0;
            sh_le_q    <= '0;
            sh_te_q    <= '0;
            sh_cl_q    <= '0;
            sh_ff_q    <= '0;
            buf_q      <= '0;
            act_q      <= '0;
            q_q        <= '0;
            buf_full_q <= 1'b0;
            cs_q       <= 1'b0;
            ur_q       <= 1'b0;
            ce_q       <= 1'b0;
        end else begin
            cs_q <= promote;

            if (!en) begin
                cnt_q <= '0;
            end else if (promote) begin
                cnt_q <= CNT_W'(1);
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // Count zero means idle or pre-first-promotion: Q freezes.
            if (cnt_q != '0) begin
                q_q <= q_d;
            end

            if (promote) begin
                sh_le_q <= leading_edge;
                sh_te_q <= trailing_edge;
                sh_cl_q <= cycle_length;
                sh_ff_q <= ff;
                if (bad_cfg) begin
                    ce_q <= 1'b1;
                end
                if (buf_full_q) begin
                    act_q      <= buf_q;
                    buf_full_q <= 1'b0;
                end else if (d_valid) begin
                    act_q <= d;
                end else begin
                    ur_q <= 1'b1;
                end
            end else if (accept) begin
                buf_q      <= d;
                buf_full_q <= 1'b1;
            end
        end
    end

    assign d_ready     = !buf_full_q;
    assign q           = q_q;
    assign cycle_start = cs_q;
    assign underrun    = ur_q;
    assign cfg_err     = ce_q;

endmodule
